// File: rtl/aurora_tx_sched_if.sv
// AXI-Stream bundle (tvalid/tdata/tlast/tready) shared by the scheduler's
// two source ports and its Aurora-facing output port.
interface aurora_tx_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tready;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/aurora_tx_sched.sv
// Packet-level TX scheduler: host (s0) vs loopback (s1) onto the Aurora stream,
// switching only between packets. Optional stall watchdog: AURORA_SCHED_WDOG_EN.
module aurora_tx_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int IPG_CYCLES  = 0,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic               m_axis_aclk,
  input  logic               m_axis_aresetn,
  input  logic               channel_up,
  input  logic [1:0]         ctrl_mode,
  aurora_tx_sched_if.slave   s0_axis,
  aurora_tx_sched_if.slave   s1_axis,
  aurora_tx_sched_if.master  m_axis,
  output logic               grant,
  output logic               busy,
  output logic [15:0]        pkt_cnt0,
  output logic [15:0]        pkt_cnt1,
  output logic               wdog_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} state_t;
  typedef enum logic [1:0] {
    MODE_HOST = 2'b00,
    MODE_LOOP = 2'b01,
    MODE_RR   = 2'b10,
    MODE_HALT = 2'b11
  } mode_t;

  localparam int GAP_W = (IPG_CYCLES > 2) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);

  state_t            r_state, w_state_nxt;
  logic              r_grant, r_rr_last;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [15:0]       r_pkt_cnt0, r_pkt_cnt1;

  logic                  w_elig0, w_elig1, w_arb_req, w_arb_src;
  logic                  w_sel_tvalid, w_sel_tlast;
  logic [DATA_WIDTH-1:0] w_sel_tdata;
  logic                  w_beat, w_last_beat, w_wdog_trip;

  // Arbitration: mode is only looked at here, i.e. while IDLE.
  always_comb begin
    w_elig0   = s0_axis.tvalid & channel_up &
                ((ctrl_mode == MODE_HOST) | (ctrl_mode == MODE_RR));
    w_elig1   = s1_axis.tvalid & channel_up &
                ((ctrl_mode == MODE_LOOP) | (ctrl_mode == MODE_RR));
    w_arb_req = (r_state == ST_IDLE) & (w_elig0 | w_elig1);
    w_arb_src = (w_elig0 & w_elig1) ? ~r_rr_last : w_elig1;
  end

  // NOTE: every output gets a default before the case logic, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_sel_tvalid   = r_grant ? s1_axis.tvalid : s0_axis.tvalid;
    w_sel_tdata    = r_grant ? s1_axis.tdata  : s0_axis.tdata;
    w_sel_tlast    = r_grant ? s1_axis.tlast  : s0_axis.tlast;
    m_axis.tvalid  = 1'b0;
    m_axis.tdata   = '0;
    m_axis.tlast   = 1'b0;
    s0_axis.tready = 1'b0;
    s1_axis.tready = 1'b0;
    if (r_state == ST_XFER) begin
      m_axis.tvalid = w_sel_tvalid;
      m_axis.tdata  = w_sel_tdata;
      m_axis.tlast  = w_sel_tlast;
      if (r_grant) s1_axis.tready = m_axis.tready;
      else         s0_axis.tready = m_axis.tready;
    end
  end

  assign w_beat      = (r_state == ST_XFER) & w_sel_tvalid & m_axis.tready;
  assign w_last_beat = w_beat & w_sel_tlast;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_arb_req) w_state_nxt = ST_XFER;
      ST_XFER: begin
        if (w_last_beat)      w_state_nxt = (IPG_CYCLES > 0) ? ST_GAP : ST_IDLE;
        else if (w_wdog_trip) w_state_nxt = ST_IDLE;
      end
      ST_GAP:  if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: asynchronous assert via the negedge in the sensitivity list; release
  // is synchronised upstream of this block.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_state    <= ST_IDLE;
      r_grant    <= 1'b0;
      r_rr_last  <= 1'b1;
      r_gap_cnt  <= '0;
      r_pkt_cnt0 <= '0;
      r_pkt_cnt1 <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      r_state <= w_state_nxt;
      if (w_arb_req) begin
        r_grant   <= w_arb_src;
        r_rr_last <= w_arb_src;
      end
      if (w_last_beat) begin
        if (r_grant) r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
        else         r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
      end
      if ((w_state_nxt == ST_GAP) && (r_state != ST_GAP))
        r_gap_cnt <= GAP_LOAD;
      else if ((r_state == ST_GAP) && (r_gap_cnt != '0))
        r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

`ifdef AURORA_SCHED_WDOG_EN
  logic [31:0] r_wdog_cnt;
  logic        r_wdog_err;

  // Trips on the WDOG_CYCLES-th consecutive XFER cycle without an accepted beat.
  assign w_wdog_trip = (r_state == ST_XFER) & ~w_beat &
                       ((r_wdog_cnt + 32'd1) == 32'(WDOG_CYCLES));

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if ((r_state != ST_XFER) || w_beat || w_wdog_trip) r_wdog_cnt <= '0;
      else                                               r_wdog_cnt <= r_wdog_cnt + 32'd1;
      if (w_wdog_trip) r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  assign w_wdog_trip = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  assign grant    = r_grant;
  assign busy     = (r_state != ST_IDLE);
  assign pkt_cnt0 = r_pkt_cnt0;
  assign pkt_cnt1 = r_pkt_cnt1;

endmodule

// File: tb/tb_aurora_tx_sched.sv
// Scoreboard bench for aurora_tx_sched: expected beats are queued in arbitration
// order at stimulus time and a negedge monitor pops them as the DUT emits beats.
module tb_aurora_tx_sched;

  logic        clk;
  logic        rst_n;
  logic        channel_up;
  logic [1:0]  ctrl_mode;
  logic        grant, busy, wdog_err;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic        g_grant, g_busy, g_wdog_err;
  logic [15:0] g_pkt_cnt0, g_pkt_cnt1;

  aurora_tx_sched_if #(.DATA_WIDTH(32)) s0_if ();
  aurora_tx_sched_if #(.DATA_WIDTH(32)) s1_if ();
  aurora_tx_sched_if #(.DATA_WIDTH(32)) m_if ();
  aurora_tx_sched_if #(.DATA_WIDTH(32)) g_s0_if ();
  aurora_tx_sched_if #(.DATA_WIDTH(32)) g_s1_if ();
  aurora_tx_sched_if #(.DATA_WIDTH(32)) g_m_if ();

  aurora_tx_sched #(.DATA_WIDTH(32), .IPG_CYCLES(0), .WDOG_CYCLES(16)) u_dut (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .channel_up(channel_up),
    .ctrl_mode(ctrl_mode), .s0_axis(s0_if), .s1_axis(s1_if), .m_axis(m_if),
    .grant(grant), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
    .wdog_err(wdog_err)
  );

  aurora_tx_sched #(.DATA_WIDTH(32), .IPG_CYCLES(3), .WDOG_CYCLES(16)) u_dut_gap (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .channel_up(1'b1),
    .ctrl_mode(2'b00), .s0_axis(g_s0_if), .s1_axis(g_s1_if), .m_axis(g_m_if),
    .grant(g_grant), .busy(g_busy), .pkt_cnt0(g_pkt_cnt0), .pkt_cnt1(g_pkt_cnt1),
    .wdog_err(g_wdog_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        src;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    cyc      = 0;
  int    beat_cnt = 0;
  int    viol     = 0;
  int    rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never
  bit    phase_a  = 0;
  int    exp_cnt0 = 0;
  int    exp_cnt1 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a packet's beats and its counter credit, queued in the
  // order the arbitration rules say it must appear.
  function automatic void push_pkt(input bit src, input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{data: base + 32'(i), last: (i == len - 1), src: src});
    if (src) exp_cnt1++;
    else     exp_cnt0++;
  endfunction

  // Sink-side ready pattern, changed 1 time unit after each rising edge.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ~m_if.tready;
        2:       m_if.tready = ($urandom_range(0, 3) != 0);
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted output beat is matched against the queue head.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst_n) begin
      if (s0_if.tready && s1_if.tready) viol++;
      if (phase_a && s1_if.tready)      viol++;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_if.tdata, e.data);
          check("beat_last", 32'(m_if.tlast), 32'(e.last));
          check("beat_src",  32'(grant), 32'(e.src));
        end
        beat_cyc_q.push_back(cyc);
        beat_cnt++;
      end
    end
  end

  task automatic drive_src(input bit src, input logic v, input logic [31:0] d, input logic l);
    if (src) begin
      s1_if.tvalid = v; s1_if.tdata = d; s1_if.tlast = l;
    end else begin
      s0_if.tvalid = v; s0_if.tdata = d; s0_if.tlast = l;
    end
  endtask

  task automatic wait_hs(input bit src);
    bit hs = 0;
    int n  = 0;
    while (!hs) begin
      @(negedge clk);
      hs = src ? (s1_if.tvalid && s1_if.tready) : (s0_if.tvalid && s0_if.tready);
      @(posedge clk);
      #1;
      n++;
      if (!hs && n > 200) begin
        n_checks++;
        n_err++;
        $display("FAIL handshake_timeout: src %0d got no tready in %0d cycles, required accept", src, n);
        return;
      end
    end
  endtask

  // Source master: holds each beat until it is accepted, then moves on.
  task automatic send_pkt(input bit src, input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      drive_src(src, 1'b1, base + 32'(i), (i == len - 1));
      wait_hs(src);
    end
    drive_src(src, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_beats(input int target);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (beat_cnt >= target) return;
    end
    n_checks++;
    n_err++;
    $display("FAIL wait_beats_timeout: got %0d beats, required %0d", beat_cnt, target);
  endtask

  initial begin
    logic [31:0] b [4];
    int          valid_cyc, first_idx, saved_cnt;

    rst_n      = 1'b0;
    channel_up = 1'b1;
    ctrl_mode  = 2'b00;
    drive_src(0, 1'b0, 32'h0, 1'b0);
    drive_src(1, 1'b0, 32'h0, 1'b0);
    g_s0_if.tvalid = 1'b0; g_s0_if.tdata = '0; g_s0_if.tlast = 1'b0;
    g_s1_if.tvalid = 1'b0; g_s1_if.tdata = '0; g_s1_if.tlast = 1'b0;
    g_m_if.tready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_tvalid",  32'(m_if.tvalid), 0);
    check("rst_s0_tready", 32'(s0_if.tready), 0);
    check("rst_s1_tready", 32'(s1_if.tready), 0);
    check("rst_grant",     32'(grant), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_pkt_cnt0",  32'(pkt_cnt0), 0);
    check("rst_pkt_cnt1",  32'(pkt_cnt1), 0);
    check("rst_wdog_err",  32'(wdog_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Host-only packet 0xA0..0xA3 at full rate
    phase_a   = 1;
    rdy_mode  = 0;
    first_idx = beat_cyc_q.size();
    push_pkt(0, 32'hA0, 4);
    valid_cyc = cyc;
    send_pkt(0, 32'hA0, 4);
    repeat (3) @(negedge clk);
    phase_a = 0;
    check("a_beats", 32'(beat_cyc_q.size() - first_idx), 4);
    if (beat_cyc_q.size() - first_idx == 4) begin
      check("a_latency", 32'(beat_cyc_q[first_idx] - valid_cyc), 1);
      for (int i = 1; i < 4; i++)
        check("a_contiguous", 32'(beat_cyc_q[first_idx + i] - beat_cyc_q[first_idx]), 32'(i));
    end
    check("a_pkt_cnt0", 32'(pkt_cnt0), 32'(exp_cnt0));
    check("a_pkt_cnt1", 32'(pkt_cnt1), 32'(exp_cnt1));

    // Round-robin from reset with both sources always pending
    do_reset();
    @(negedge clk);
    check("b_rst_pkt_cnt0", 32'(pkt_cnt0), 0);
    @(posedge clk);
    #1;
    ctrl_mode = 2'b10;
    rdy_mode  = 2;
    for (int i = 0; i < 4; i++) b[i] = $urandom;
    push_pkt(0, b[0], 3);
    push_pkt(1, b[1], 3);
    push_pkt(0, b[2], 3);
    push_pkt(1, b[3], 3);
    fork
      begin send_pkt(0, b[0], 3); send_pkt(0, b[2], 3); end
      begin send_pkt(1, b[1], 3); send_pkt(1, b[3], 3); end
    join
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("b_pkt_cnt0", 32'(pkt_cnt0), 32'(exp_cnt0));
    check("b_pkt_cnt1", 32'(pkt_cnt1), 32'(exp_cnt1));
    check("b_drained",  32'(exp_q.size()), 0);

    // Inter-packet gap of 3 on the second instance: two back-to-back 2-beat packets
    begin
      int bc[4];
      bit bl[64];
      int idx = 0;
      @(posedge clk);
      #1;
      g_s0_if.tvalid = 1'b1; g_s0_if.tdata = 32'h50; g_s0_if.tlast = 1'b0;
      for (int c = 0; c < 60 && idx < 4; c++) begin
        @(negedge clk);
        bl[c] = g_busy;
        if (g_m_if.tvalid && g_m_if.tready) begin
          check("c_data", g_m_if.tdata, 32'h50 + 32'(idx));
          bc[idx] = c;
          idx++;
        end
        @(posedge clk);
        #1;
        g_s0_if.tvalid = (idx < 4);
        g_s0_if.tdata  = 32'h50 + 32'(idx);
        g_s0_if.tlast  = (idx == 1) || (idx == 3);
      end
      g_s0_if.tvalid = 1'b0;
      check("c_beats", 32'(idx), 4);
      if (idx == 4 && bc[1] + 4 < 64) begin
        check("c_gap_span", 32'(bc[2] - bc[1]), 5);
        for (int k = 1; k <= 3; k++) check("c_busy_gap", 32'(bl[bc[1] + k]), 1);
        check("c_idle_after_gap", 32'(bl[bc[1] + 4]), 0);
      end
      check("c_pkt_cnt0", 32'(g_pkt_cnt0), 2);
    end

    // Link down blocks admission; mid-packet link drop and mode change do not cut it
    ctrl_mode  = 2'b00;
    channel_up = 1'b0;
    b[0] = $urandom;
    b[1] = $urandom;
    push_pkt(0, b[0], 4);
    push_pkt(1, b[1], 3);
    saved_cnt = beat_cnt;
    fork
      send_pkt(0, b[0], 4);
      begin
        repeat (5) @(negedge clk);
        check("d_no_grant_tvalid", 32'(m_if.tvalid), 0);
        check("d_no_grant_busy",   32'(busy), 0);
        check("d_no_grant_tready", 32'(s0_if.tready), 0);
        @(posedge clk);
        #1;
        channel_up = 1'b1;
        wait_beats(saved_cnt + 2);
        @(posedge clk);
        #1;
        channel_up = 1'b0;
        ctrl_mode  = 2'b01;
      end
    join
    fork
      send_pkt(1, b[1], 3);
      begin
        repeat (4) @(negedge clk);
        check("d_link_down_busy",   32'(busy), 0);
        check("d_link_down_tready", 32'(s1_if.tready), 0);
        @(posedge clk);
        #1;
        channel_up = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    check("d_pkt_cnt0", 32'(pkt_cnt0), 32'(exp_cnt0));
    check("d_pkt_cnt1", 32'(pkt_cnt1), 32'(exp_cnt1));

    // Backpressure: ready toggles every cycle during a 5-beat host packet
    ctrl_mode = 2'b00;
    rdy_mode  = 1;
    b[0] = $urandom;
    push_pkt(0, b[0], 5);
    send_pkt(0, b[0], 5);
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("e_pkt_cnt0", 32'(pkt_cnt0), 32'(exp_cnt0));
    check("e_drained",  32'(exp_q.size()), 0);

`ifdef AURORA_SCHED_WDOG_EN
    // Stall watchdog: 16 cycles without an accepted beat abort the packet
    rdy_mode  = 3;
    saved_cnt = exp_cnt0;
    b[0] = $urandom;
    push_pkt(0, b[0], 3);
    fork
      send_pkt(0, b[0], 3);
      begin
        int stall = 0;
        bit seen  = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
          @(negedge clk);
          if (wdog_err) seen = 1;
          else if (busy) stall++;
        end
        check("f_wdog_seen",    32'(seen), 1);
        check("f_wdog_stall",   32'(stall), 16);
        check("f_wdog_idle",    32'(busy), 0);
        check("f_wdog_cnt_hold", 32'(pkt_cnt0), 32'(saved_cnt));
        @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    repeat (3) @(negedge clk);
    check("f_wdog_sticky", 32'(wdog_err), 1);
    check("f_pkt_cnt0",    32'(pkt_cnt0), 32'(exp_cnt0));
    do_reset();
    @(negedge clk);
    check("f_wdog_cleared", 32'(wdog_err), 0);
`else
    check("wdog_tied_low", 32'(wdog_err), 0);
`endif

    repeat (4) @(negedge clk);
    check("final_drained",    32'(exp_q.size()), 0);
    check("tready_exclusive", 32'(viol), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/aurora_tx_sched.md
Name: aurora_tx_sched

Overview:
- Packet-level scheduler for the Aurora TX AXI-Stream. It arbitrates between the host path (output of the pre module) and the loopback FIFO output.
- It replaces the combinational ctrl_loopback mux. Source switching happens only on packet boundaries, and new packets are admitted only while channel_up is high.
- An optional inter-packet gap is inserted after each packet. Per-source packet counters are provided for the future AXI register wrapper.

Parameters:
DATA_WIDTH, 32, tdata width of all streams
IPG_CYCLES, 0, idle cycles forced after each packet's tlast beat (0 = none)
WDOG_CYCLES, 1024, stall limit used only when AURORA_SCHED_WDOG_EN is defined

Ports:
m_axis_aclk  in  1  user_clk_out domain clock
m_axis_aresetn  in  1  asynchronous active-low reset
channel_up  in  1  Aurora link status
ctrl_mode  in  2  00 host only, 01 loopback only, 10 round-robin, 11 halt
s0_axis_tvalid/tdata/tlast  in  1/DATA_WIDTH/1  host source
s0_axis_tready  out  1
s1_axis_tvalid/tdata/tlast  in  1/DATA_WIDTH/1  loopback source
s1_axis_tready  out  1
m_axis_tvalid/tdata/tlast  out  1/DATA_WIDTH/1  to Aurora s_axi_tx
m_axis_tready  in  1
grant  out  1  source currently or last granted (0 = host)
busy  out  1  high in XFER or GAP
pkt_cnt0, pkt_cnt1  out  16  packets forwarded per source
wdog_err  out  1  sticky stall flag (0 when feature is compiled out)

Behaviour:
- Reset (async assert, sync release): state IDLE. grant=0, rr_last=1, busy=0, pkt_cnt0=0, pkt_cnt1=0, wdog_err=0, gap counter=0. All tvalid and tready outputs are 0.
- States: IDLE, XFER, GAP.
- IDLE:
  - All treadys and m_axis_tvalid are 0.
  - ctrl_mode is sampled only in IDLE.
  - Eligibility: sN is eligible if sN_tvalid=1, the mode permits N, and channel_up=1.
  - Mode 00 permits s0 only. Mode 01 permits s1 only. Mode 11 permits none, so the block stays in IDLE.
  - Mode 10 with both eligible: grant = !rr_last. With one eligible: grant goes to that source.
  - On a grant, update grant and rr_last, then go to XFER next cycle. Arbitration latency is 1 cycle from tvalid to the first possible beat.
- XFER:
  - Zero-latency pass-through of the granted source: m_axis_t* = s{grant}_axis_t*, s{grant}_axis_tready = m_axis_tready.
  - The non-granted tready is held at 0.
  - On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast:
    - increment pkt_cnt{grant}; the counter wraps 0xFFFF -> 0;
    - go to GAP if IPG_CYCLES>0, else go to IDLE.
  - Back-to-back packets from the same source therefore have a 1-cycle bubble minimum.
- GAP: load the counter with IPG_CYCLES-1 on entry. Outputs are idle. Go to IDLE when the counter reaches 0.
- Mid-packet events:
  - A channel_up drop or ctrl_mode change does not break a packet. The packet completes; the stall comes from Aurora tready.
  - Halt mode takes effect at the next IDLE.
- Both sources asserting tlast in the same cycle: only the granted source is relevant.
- Reset mid-packet: outputs are cleared immediately. The partial packet is lost downstream; Aurora reset recovers framing.
- busy = (state != IDLE).
- No combinational path from m_axis_tready to m_axis_tvalid.

Optional Feature:
- Macro: AURORA_SCHED_WDOG_EN.
- Defined:
  - In XFER, a 32-bit counter counts consecutive cycles without an accepted beat; it resets on any accepted beat.
  - When the counter reaches WDOG_CYCLES: set wdog_err (sticky until reset) and force state to IDLE without incrementing pkt_cnt.
  - The remaining beats of the aborted packet are forwarded as a new packet on the next grant. This is a documented framing loss.
- Undefined: no counter logic; wdog_err is tied to 0; XFER waits indefinitely.

Test Plan:
- Mode 00, channel_up=1, 4-beat host packet 0xA0..0xA3, m_axis_tready=1:
  - first beat 1 cycle after s0_axis_tvalid;
  - 4 contiguous beats, tlast on 0xA3;
  - pkt_cnt0=1; s1_axis_tready stays 0.
- Mode 10, both sources hold 3-beat packets continuously:
  - grant order 0,1,0,1;
  - each packet is contiguous with no interleaving;
  - after 4 packets, pkt_cnt0=2 and pkt_cnt1=2.
- IPG_CYCLES=3, two back-to-back host packets:
  - exactly 3 GAP cycles plus 1 IDLE cycle between the first tlast and the second first beat;
  - busy is high during GAP.
- channel_up=0 with s0_axis_tvalid=1:
  - no grant; outputs idle.
  - Raise channel_up; during the packet, drop channel_up and switch ctrl_mode to 01: the packet completes unchanged, and the next grant goes to s1.
- Backpressure: toggle m_axis_tready every cycle during a 5-beat packet; the data order is preserved and each beat is transferred once.
- AURORA_SCHED_WDOG_EN, WDOG_CYCLES=16: hold m_axis_tready=0 in XFER for 16 cycles; wdog_err=1, state=IDLE, pkt_cnt unchanged, wdog_err held until reset.
